imu_arbiter: RTL and testbench
==============================

Name: imu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one IMU (index match unit) between NREQ requesters.
- Each request is one lookup: a 32-bit value plus a row block of LANES 32-bit indices.
- The block grants one requester, drives the IMU, waits for CBB_valid, captures the 128-bit IMU data, and returns it tagged with the requester ID.
- One lookup is outstanding at a time. A watchdog ends lookups that never complete.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LANES, 4, 32-bit row indices per request (row width = 32*LANES).
- TIMEOUT, 64, WAIT cycles before a lookup is aborted with an error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot pulse.
- req_value  in  32*NREQ  value of requester i at bits [32i+31:32i].
- req_row  in  32*LANES*NREQ  row block of requester i, packed in the same order.
- imu_value  out  32  value driven to the IMU.
- imu_row  out  32*LANES  row driven to the IMU.
- imu_start  out  1  one-cycle pulse that starts an IMU lookup.
- imu_data  in  32*LANES  IMU result data.
- imu_cbb_valid  in  1  IMU result valid (CBB_valid).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  clog2(NREQ)  index of the requester that issued the lookup.
- resp_data  out  32*LANES  captured IMU data.
- resp_err  out  1  1 = lookup timed out; resp_data is 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, imu_value, imu_row, imu_start, resp_valid, resp_id, resp_data, resp_err, busy.
  - Timeout counter cleared.
  - Reset mid-operation abandons the lookup silently; no response is produced.
- State machine (registered) has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching circularly from rr_ptr+1.
  - In the same cycle: req_ready[g]=1 (combinational, one-hot); latch req_value[g] and req_row[g] into imu_value/imu_row; latch g into resp_id; set rr_ptr=g; go to ISSUE.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- ISSUE:
  - imu_start=1 for exactly this one cycle; imu_value/imu_row are stable.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - imu_value/imu_row are held constant.
  - imu_cbb_valid is sampled every cycle. In the first WAIT cycle with imu_cbb_valid=1: resp_data<=imu_data, resp_err<=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no valid: resp_data<=0, resp_err<=1, go to RESP.
  - imu_cbb_valid outside WAIT is ignored.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are stable until the handshake.
  - On resp_valid & resp_ready: drop resp_valid next cycle and go to IDLE.
- Latency: a grant in cycle T produces imu_start at T+1. With imu_cbb_valid first high at cycle T+1+k (k≥1), resp_valid rises at T+2+k.
- Minimum spacing between consecutive grants is 4 cycles (IDLE, ISSUE, WAIT, RESP, with immediate resp_ready).
- Fairness:
  - A requester held valid is granted within NREQ lookups.
  - A requester that drops req_valid before its grant is simply skipped.
  - req_valid/value/row must be held until req_ready.
- At most one req_ready bit is high per cycle; req_ready is 0 outside IDLE.
- Counter width is clog2(TIMEOUT)+1 and it saturates; there is no wrap.

Test Plan:
1. Reset release, req 0 only:
   - Stimulus: value=5, row={3,2,1,0}; the IMU model asserts CBB_valid 2 cycles after imu_start with data 0x...0001.
   - Required: req_ready[0] pulses once; imu_value=5; resp_valid rises at grant+4 with resp_id=0, resp_data=model data, resp_err=0.
2. All 4 requesters valid continuously:
   - Required: grant order 0,1,2,3,0; each grant has exactly one req_ready bit high.
3. Model never asserts CBB_valid, TIMEOUT=64:
   - Required: resp_valid with resp_err=1 and resp_data=0 exactly 64 cycles after imu_start; the next request is served normally.
4. resp_ready held low for 10 cycles in RESP:
   - Required: resp_* stable for all 10 cycles; no new req_ready during them; IDLE entered the cycle after resp_ready rises.
5. rst pulsed low mid-WAIT:
   - Required: all outputs 0 immediately (asynchronous); no response emitted; after release requester 0 has first priority.
6. CBB_valid held high before and during ISSUE:
   - Required: ignored until WAIT, then captured on the first WAIT cycle; latency is grant+3.

Source files
------------

// File: rtl/imu_arbiter_if.sv
// imu_arbiter_if: requester, IMU and response signal bundle shared by the
// arbiter (slave side) and whatever surrounds it (master side).
interface imu_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int LANES = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW  = 32 * LANES;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_value;
    logic [RW*NREQ-1:0] req_row;

    logic [31:0]        imu_value;
    logic [RW-1:0]      imu_row;
    logic               imu_start;
    logic [RW-1:0]      imu_data;
    logic               imu_cbb_valid;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [RW-1:0]      resp_data;
    logic               resp_err;

    modport slave (
        input  req_valid, req_value, req_row, imu_data, imu_cbb_valid, resp_ready,
        output req_ready, imu_value, imu_row, imu_start, resp_valid, resp_id,
               resp_data, resp_err
    );

    modport master (
        output req_valid, req_value, req_row, imu_data, imu_cbb_valid, resp_ready,
        input  req_ready, imu_value, imu_row, imu_start, resp_valid, resp_id,
               resp_data, resp_err
    );
endinterface

// File: rtl/imu_arbiter.sv
// imu_arbiter: round-robin arbiter that shares one index match unit between
// NREQ requesters. One lookup is outstanding at a time; a watchdog turns a
// lookup that never sees CBB_valid into an error response with zero data.
module imu_arbiter #(
    parameter int NREQ    = 4,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    imu_arbiter_if.slave   bus,
    output logic           busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TIMEOUT) + 1;
    localparam int RW  = 32 * LANES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_resp_id;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_imu_value;
    logic [RW-1:0]   r_imu_row;
    logic [RW-1:0]   r_resp_data;
    logic            r_imu_start;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic            r_busy;

    logic            w_any;
    logic [IDW-1:0]  w_gnt;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_idx;
    logic [31:0]     w_sel_value;
    logic [RW-1:0]   w_sel_row;
    logic [NREQ-1:0] w_ready;

    // Circular priority search: first valid requester after the last grant
    always_comb begin
        w_any = 1'b0;
        w_gnt = {IDW{1'b0}};
        w_sum = {(IDW+1){1'b0}};
        w_idx = {IDW{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end else begin
                w_any = w_any;
            end
        end
    end

    // Pick out the granted requester's value and row block
    always_comb begin
        w_sel_value = 32'd0;
        w_sel_row   = {RW{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            if (IDW'(j) == w_gnt) begin
                w_sel_value = bus.req_value[32*j +: 32];
                w_sel_row   = bus.req_row[RW*j +: RW];
            end else begin
                w_sel_value = w_sel_value;
            end
        end
    end

    // One-hot accept pulse, only while idle and out of reset
    always_comb begin
        w_ready = {NREQ{1'b0}};
        if (rst && (r_state == S_IDLE) && w_any) begin
            w_ready[w_gnt] = 1'b1;
        end else begin
            w_ready = {NREQ{1'b0}};
        end
    end

    // Sequencer: grant, issue, wait for the IMU or the watchdog, hold the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= IDW'(NREQ - 1);
            r_resp_id    <= {IDW{1'b0}};
            r_cnt        <= {CW{1'b0}};
            r_imu_value  <= 32'd0;
            r_imu_row    <= {RW{1'b0}};
            r_resp_data  <= {RW{1'b0}};
            r_imu_start  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_imu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_imu_value <= w_sel_value;
                        r_imu_row   <= w_sel_row;
                        r_resp_id   <= w_gnt;
                        r_rr_ptr    <= w_gnt;
                        r_imu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= {CW{1'b0}};
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imu_cbb_valid) begin
                        r_resp_data  <= bus.imu_data;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_cnt + CW'(1) == CW'(TIMEOUT - 1)) begin
                        // Watchdog expiry: data is forced to zero with the error flag
                        r_resp_data  <= {RW{1'b0}};
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.imu_value  = r_imu_value;
    assign bus.imu_row    = r_imu_row;
    assign bus.imu_start  = r_imu_start;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign busy           = r_busy;
endmodule

// File: tb/tb_imu_arbiter.sv
// tb_imu_arbiter: scenario tasks driving imu_arbiter with a behavioural IMU
// model and a round-robin reference computed from the grant rules.
module tb_imu_arbiter;
    localparam int NREQ    = 4;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 64;
    localparam int RW      = 32 * LANES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    imu_arbiter_if #(.NREQ(NREQ), .LANES(LANES)) bus ();

    imu_arbiter #(.NREQ(NREQ), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]     vals [NREQ];
    logic [RW-1:0]   rows [NREQ];
    logic [NREQ-1:0] vmask;
    int              ref_ptr;

    // IMU model controls: lat = cycles after imu_start until CBB_valid (0 = never)
    bit              imu_auto = 1'b1;
    int              imu_lat  = 2;
    logic [RW-1:0]   imu_next;
    int              imu_cd   = -1;

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int l = 0; l < LANES; l++) r[32*l +: 32] = $urandom;
        return r;
    endfunction

    // Reference: next requester after ptr, going round the ring
    function automatic int ref_grant(int ptr, logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        bus.req_valid = vmask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_value[32*i +: 32] = vals[i];
            bus.req_row[RW*i +: RW]   = rows[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int id, output logic [NREQ-1:0] rdy, output bit ok);
        ok  = 1'b0;
        id  = -1;
        rdy = '0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (|bus.req_ready) begin
                rdy = bus.req_ready;
                for (int i = 0; i < NREQ; i++) if (rdy[i]) id = i;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_resp(output int cycles, output bit ok);
        cycles = 0;
        while (!bus.resp_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        ok = bus.resp_valid;
    endtask

    // Behavioural IMU: answers imu_lat cycles after the start pulse, junk data otherwise
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imu_auto) begin
                if (!rst) imu_cd = -1;
                bus.imu_cbb_valid = 1'b0;
                bus.imu_data      = rnd_row();
                if (imu_cd > 0) begin
                    imu_cd--;
                    if (imu_cd == 0) begin
                        bus.imu_cbb_valid = 1'b1;
                        bus.imu_data      = imu_next;
                        imu_cd            = -1;
                    end
                end
                if (bus.imu_start === 1'b1 && imu_lat > 0) imu_cd = imu_lat;
            end
        end
    end

    task automatic test_reset();
        rst   = 1'b0;
        vmask = '1;
        drive_reqs();
        tick();
        tick();
        n_checks++;
        if (bus.req_ready !== '0 || bus.imu_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b start=%b busy=%b expected 0", bus.req_ready, bus.imu_start, busy);
        end
        n_checks++;
        if (bus.imu_value !== 32'd0 || bus.imu_row !== '0 || bus.resp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: value=%0h row=%0h data=%0h expected 0", bus.imu_value, bus.imu_row, bus.resp_data);
        end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_id !== '0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b id=%0d err=%b expected 0", bus.resp_valid, bus.resp_id, bus.resp_err);
        end
        vmask = '0;
        drive_reqs();
        rst     = 1'b1;
        ref_ptr = NREQ - 1;
    endtask

    task automatic test_single();
        int id, cyc;
        logic [NREQ-1:0] rdy;
        bit ok;
        vals[0]  = 32'd5;
        rows[0]  = {32'd3, 32'd2, 32'd1, 32'd0};
        vmask    = NREQ'(1);
        drive_reqs();
        imu_lat  = 2;
        imu_next = RW'(1);
        wait_grant(id, rdy, ok);
        n_checks++;
        if (!ok || rdy !== NREQ'(1)) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected %b", rdy, NREQ'(1));
        end
        ref_ptr = 0;
        tick();
        n_checks++;
        if (bus.imu_start !== 1'b1 || bus.imu_value !== 32'd5 || bus.imu_row !== rows[0] || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL single_issue: start=%b value=%0h row=%0h expected 1 5 %0h", bus.imu_start, bus.imu_value, bus.imu_row, rows[0]);
        end
        vmask = '0;
        drive_reqs();
        wait_resp(cyc, ok);
        n_checks++;
        if (!ok || cyc + 1 != 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 4", cyc + 1);
        end
        n_checks++;
        if (bus.resp_id !== 2'd0 || bus.resp_data !== imu_next || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: id=%0d data=%0h err=%b expected 0 %0h 0", bus.resp_id, bus.resp_data, bus.resp_err, imu_next);
        end
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: valid=%b busy=%b expected 0 0", bus.resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int id, cyc, exp;
        logic [NREQ-1:0] rdy;
        logic [RW-1:0] d;
        bit ok;
        int order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        ref_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            vals[i] = $urandom;
            rows[i] = rnd_row();
        end
        vmask = '1;
        drive_reqs();
        bus.resp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp = ref_grant(ref_ptr, vmask);
            wait_grant(id, rdy, ok);
            n_checks++;
            if (!ok || rdy !== (NREQ'(1) << exp) || id != order[n]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b expected requester %0d", n, rdy, order[n]);
            end
            ref_ptr  = exp;
            imu_lat  = $urandom_range(1, 4);
            imu_next = rnd_row();
            d        = imu_next;
            tick();
            n_checks++;
            if (bus.imu_start !== 1'b1 || bus.imu_value !== vals[exp] || bus.imu_row !== rows[exp]) begin
                n_fail++;
                $display("FAIL rr_issue%0d: value=%0h expected %0h", n, bus.imu_value, vals[exp]);
            end
            vals[exp] = $urandom;
            rows[exp] = rnd_row();
            drive_reqs();
            wait_resp(cyc, ok);
            n_checks++;
            if (!ok || cyc + 1 != imu_lat + 2 || bus.resp_id !== 2'(exp) || bus.resp_data !== d || bus.resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_resp%0d: lat=%0d id=%0d expected lat=%0d id=%0d", n, cyc + 1, bus.resp_id, imu_lat + 2, exp);
            end
            tick();
        end
        vmask = '0;
        drive_reqs();
    endtask

    task automatic test_timeout();
        int id, cyc, exp;
        logic [NREQ-1:0] rdy;
        bit ok;
        vmask   = NREQ'(4);
        drive_reqs();
        imu_lat = 0;
        exp     = ref_grant(ref_ptr, vmask);
        wait_grant(id, rdy, ok);
        ref_ptr = exp;
        tick();
        vmask = '0;
        drive_reqs();
        wait_resp(cyc, ok);
        n_checks++;
        if (!ok || cyc != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d expected %0d", cyc, TIMEOUT);
        end
        n_checks++;
        if (bus.resp_err !== 1'b1 || bus.resp_data !== '0 || bus.resp_id !== 2'(exp) || bus.imu_value !== vals[exp]) begin
            n_fail++;
            $display("FAIL timeout_resp: err=%b data=%0h id=%0d expected 1 0 %0d", bus.resp_err, bus.resp_data, bus.resp_id, exp);
        end
        tick();
        vmask    = NREQ'(2);
        drive_reqs();
        imu_lat  = 3;
        imu_next = rnd_row();
        exp      = ref_grant(ref_ptr, vmask);
        wait_grant(id, rdy, ok);
        ref_ptr = exp;
        tick();
        vmask = '0;
        drive_reqs();
        wait_resp(cyc, ok);
        n_checks++;
        if (!ok || cyc + 1 != 5 || bus.resp_err !== 1'b0 || bus.resp_data !== imu_next || bus.resp_id !== 2'(exp)) begin
            n_fail++;
            $display("FAIL timeout_next: lat=%0d err=%b id=%0d expected 5 0 %0d", cyc + 1, bus.resp_err, bus.resp_id, exp);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int id, cyc, exp;
        logic [NREQ-1:0] rdy;
        logic [RW-1:0] d;
        logic [1:0] rid;
        logic rerr;
        bit ok;
        bus.resp_ready = 1'b0;
        vmask    = NREQ'(8);
        drive_reqs();
        imu_lat  = 1;
        imu_next = rnd_row();
        exp      = ref_grant(ref_ptr, vmask);
        wait_grant(id, rdy, ok);
        ref_ptr = exp;
        tick();
        vmask = '1;
        drive_reqs();
        wait_resp(cyc, ok);
        d    = bus.resp_data;
        rid  = bus.resp_id;
        rerr = bus.resp_err;
        n_checks++;
        if (!ok || d !== imu_next || rid !== 2'(exp)) begin
            n_fail++;
            $display("FAIL bp_first: id=%0d data=%0h expected %0d %0h", rid, d, exp, imu_next);
        end
        for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== d || bus.resp_id !== rid || bus.resp_err !== rerr || bus.req_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b id=%0d expected 1 0 %0d", j, bus.resp_valid, bus.req_ready, bus.resp_id, rid);
            end
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        exp = ref_grant(ref_ptr, vmask);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== (NREQ'(1) << exp)) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0 %b", bus.resp_valid, bus.req_ready, NREQ'(1) << exp);
        end
        ref_ptr = exp;
        tick();
        vmask = '0;
        drive_reqs();
        wait_resp(cyc, ok);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int id, cyc;
        logic [NREQ-1:0] rdy;
        bit ok;
        vmask   = NREQ'(4);
        drive_reqs();
        imu_lat = 0;
        wait_grant(id, rdy, ok);
        tick();
        vmask = '1;
        drive_reqs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== '0 || bus.imu_start !== 1'b0 || busy !== 1'b0 || bus.imu_value !== 32'd0 || bus.imu_row !== '0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: ready=%b busy=%b value=%0h expected 0", bus.req_ready, busy, bus.imu_value);
        end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_id !== '0 || bus.resp_data !== '0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_resp: valid=%b id=%0d err=%b expected 0", bus.resp_valid, bus.resp_id, bus.resp_err);
        end
        tick();
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_resp: valid=%b expected 0", bus.resp_valid);
        end
        imu_lat  = 2;
        imu_next = rnd_row();
        rst      = 1'b1;
        ref_ptr  = NREQ - 1;
        wait_grant(id, rdy, ok);
        n_checks++;
        if (!ok || rdy !== NREQ'(1)) begin
            n_fail++;
            $display("FAIL rst_priority: got %b expected %b", rdy, NREQ'(1));
        end
        ref_ptr = 0;
        tick();
        vmask = '0;
        drive_reqs();
        wait_resp(cyc, ok);
        n_checks++;
        if (!ok || bus.resp_id !== 2'd0 || bus.resp_data !== imu_next || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: id=%0d data=%0h expected 0 %0h", bus.resp_id, bus.resp_data, imu_next);
        end
        tick();
    endtask

    task automatic test_cbb_early();
        int id, exp;
        logic [NREQ-1:0] rdy;
        logic [RW-1:0] d2;
        bit ok;
        imu_auto          = 1'b0;
        bus.imu_cbb_valid = 1'b1;
        bus.imu_data      = rnd_row();
        vmask = NREQ'(2);
        drive_reqs();
        exp = ref_grant(ref_ptr, vmask);
        wait_grant(id, rdy, ok);
        ref_ptr = exp;
        tick();
        bus.imu_data = rnd_row();
        vmask = '0;
        drive_reqs();
        tick();
        d2 = rnd_row();
        bus.imu_data = d2;
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ignored: valid=%b expected 0", bus.resp_valid);
        end
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== d2 || bus.resp_id !== 2'(exp)) begin
            n_fail++;
            $display("FAIL early_capture: valid=%b data=%0h expected 1 %0h", bus.resp_valid, bus.resp_data, d2);
        end
        bus.imu_cbb_valid = 1'b0;
        imu_auto          = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int id, cyc, exp, bp;
        logic [NREQ-1:0] rdy;
        logic [RW-1:0] d;
        bit ok;
        vmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        drive_reqs();
        for (int n = 0; n < 40; n++) begin
            exp = ref_grant(ref_ptr, vmask);
            wait_grant(id, rdy, ok);
            n_checks++;
            if (!ok || rdy !== (NREQ'(1) << exp)) begin
                n_fail++;
                $display("FAIL rand_grant%0d: got %b expected %b", n, rdy, NREQ'(1) << exp);
            end
            ref_ptr  = exp;
            imu_lat  = $urandom_range(1, 6);
            imu_next = rnd_row();
            d        = imu_next;
            bp       = $urandom_range(0, 3);
            bus.resp_ready = (bp == 0);
            tick();
            n_checks++;
            if (bus.imu_start !== 1'b1 || bus.imu_value !== vals[exp] || bus.imu_row !== rows[exp]) begin
                n_fail++;
                $display("FAIL rand_issue%0d: value=%0h expected %0h", n, bus.imu_value, vals[exp]);
            end
            vals[exp] = $urandom;
            rows[exp] = rnd_row();
            vmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drive_reqs();
            wait_resp(cyc, ok);
            n_checks++;
            if (!ok || cyc + 1 != imu_lat + 2 || bus.resp_id !== 2'(exp) || bus.resp_data !== d || bus.resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_resp%0d: lat=%0d id=%0d expected %0d %0d", n, cyc + 1, bus.resp_id, imu_lat + 2, exp);
            end
            repeat (bp) tick();
            bus.resp_ready = 1'b1;
            tick();
        end
        vmask = '0;
        drive_reqs();
    endtask

    initial begin
        bus.req_valid     = '0;
        bus.req_value     = '0;
        bus.req_row       = '0;
        bus.imu_cbb_valid = 1'b0;
        bus.imu_data      = '0;
        bus.resp_ready    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            vals[i] = 32'd0;
            rows[i] = '0;
        end
        vmask   = '0;
        ref_ptr = NREQ - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_cbb_early();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
